// File: rtl/sub_bytes_pipe.sv
`timescale 1ns/1ps
// sub_bytes_pipe: LANES parallel AES S-boxes (tower-field inverse), InvSubBytes too when SUBBYTES_INV_EN is defined.
// Latency: 2 cycles (d1 = input or inverse pre-affine, d2 = GF inverse plus optional forward affine).
// Backpressure: in_ready = !out_valid || out_ready; both stages stall together, no bubble collapsing.
module sub_bytes_pipe #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
`ifdef SUBBYTES_INV_EN
    input  logic               in_inv,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    // GF(16) uses x^4+x+1; GF(256) = GF(16)[y]/(y^2+y+LAMBDA), LAMBDA has trace 1 so it is irreducible.
    localparam logic [3:0] LAMBDA = 4'hE;

    function automatic logic [3:0] gf4_xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] a1, a2, a3;
        a1 = gf4_xtime(a);
        a2 = gf4_xtime(a1);
        a3 = gf4_xtime(a2);
        return ({4{b[0]}} & a) ^ ({4{b[1]}} & a1) ^ ({4{b[2]}} & a2) ^ ({4{b[3]}} & a3);
    endfunction

    // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    // (ah*y + al)^-1 = (ah*d^-1)*y + (ah+al)*d^-1 with norm d = ah^2*LAMBDA + ah*al + al^2.
    function automatic logic [7:0] gf8c_inv(input logic [7:0] a);
        logic [3:0] ah, al, d_inv;
        ah    = a[7:4];
        al    = a[3:0];
        d_inv = gf4_inv(gf4_mul(gf4_mul(ah, ah), LAMBDA) ^ gf4_mul(ah, al) ^ gf4_mul(al, al));
        return {gf4_mul(ah, d_inv), gf4_mul(ah ^ al, d_inv)};
    endfunction

    // Linear map given as eight packed 8-bit columns: result = XOR of columns selected by v.
    function automatic logic [7:0] apply_cols(input logic [63:0] cols, input logic [7:0] v);
        return ({8{v[0]}} & cols[7:0])   ^ ({8{v[1]}} & cols[15:8])  ^
               ({8{v[2]}} & cols[23:16]) ^ ({8{v[3]}} & cols[31:24]) ^
               ({8{v[4]}} & cols[39:32]) ^ ({8{v[5]}} & cols[47:40]) ^
               ({8{v[6]}} & cols[55:48]) ^ ({8{v[7]}} & cols[63:56]);
    endfunction

    // Isomorphism into the tower: x^i maps to beta^i, beta a tower root of x^8+x^4+x^3+x+1.
    function automatic logic [63:0] find_map();
        logic [63:0] cols;
        logic [7:0]  b, b2, b3, b4, b5, b6, b7, b8;
        logic        found;
        cols  = 64'h0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            b  = 8'(c);
            b2 = gf8c_mul(b, b);
            b3 = gf8c_mul(b2, b);
            b4 = gf8c_mul(b2, b2);
            b5 = gf8c_mul(b4, b);
            b6 = gf8c_mul(b4, b2);
            b7 = gf8c_mul(b4, b3);
            b8 = gf8c_mul(b4, b4);
            if (!found && (b8 ^ b4 ^ b3 ^ b ^ 8'h01) == 8'h00) begin
                found = 1'b1;
                cols  = {b7, b6, b5, b4, b3, b2, b, 8'h01};
            end
        end
        return cols;
    endfunction

    function automatic logic [63:0] invert_map(input logic [63:0] cols);
        logic [63:0] inv;
        logic [7:0]  img;
        inv = 64'h0;
        for (int a = 1; a < 256; a++) begin
            img = apply_cols(cols, 8'(a));
            case (img)
                8'h01:   inv[7:0]   = 8'(a);
                8'h02:   inv[15:8]  = 8'(a);
                8'h04:   inv[23:16] = 8'(a);
                8'h08:   inv[31:24] = 8'(a);
                8'h10:   inv[39:32] = 8'(a);
                8'h20:   inv[47:40] = 8'(a);
                8'h40:   inv[55:48] = 8'(a);
                8'h80:   inv[63:56] = 8'(a);
                default: ;
            endcase
        end
        return inv;
    endfunction

    localparam logic [63:0] TO_TOWER   = find_map();
    localparam logic [63:0] FROM_TOWER = invert_map(TO_TOWER);

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        return apply_cols(FROM_TOWER, gf8c_inv(apply_cols(TO_TOWER, a)));
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] s);
        return s ^ {s[3:0], s[7:4]} ^ {s[4:0], s[7:5]} ^ {s[5:0], s[7:6]} ^ {s[6:0], s[7]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_pre_affine(input logic [7:0] s);
        return {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
    endfunction

    logic               v1, v2, inv1, en, inv_sel;
    logic [8*LANES-1:0] d1, d2, d1_nxt, d2_nxt;

    assign en        = !v2 || out_ready;
    assign in_ready  = en;
    assign out_valid = v2;
    assign out_data  = d2;
    assign busy      = v1 || v2;

`ifdef SUBBYTES_INV_EN
    assign inv_sel = in_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv1 <= 1'b0;
        end else if (en) begin
            inv1 <= in_inv;
        end
    end
`else
    assign inv_sel = 1'b0;
    assign inv1    = 1'b0;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] inv_byte;
        assign d1_nxt[8*k +: 8] = inv_sel ? inv_pre_affine(in_data[8*k +: 8]) : in_data[8*k +: 8];
        assign inv_byte         = gf_inv(d1[8*k +: 8]);
        assign d2_nxt[8*k +: 8] = inv1 ? inv_byte : fwd_affine(inv_byte);
    end

    // Data registers load on every advance; their contents only matter under the matching valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else if (en) begin
            v1 <= in_valid && in_ready;
            v2 <= v1;
            d1 <= d1_nxt;
            d2 <= d2_nxt;
        end
    end

endmodule
